// File: rtl/boot_reset_seq_if.sv
// Board boot/reset signal bundle between the board top and boot_reset_seq.
// The sequencer uses the slave view; the board side (or a bench) uses master.
interface boot_reset_seq_if;
  logic       pll_lock;
  logic       btn_rst;
  logic       init_done;
  logic       loader_txd;
  logic       soc_txd;
  logic       soc_rst_n;
  logic       o_tx;
  logic       tx_sel;
  logic [2:0] boot_state;
  logic [7:0] rst_count;

  modport master (
    output pll_lock,
    output btn_rst,
    output init_done,
    output loader_txd,
    output soc_txd,
    input  soc_rst_n,
    input  o_tx,
    input  tx_sel,
    input  boot_state,
    input  rst_count
  );

  modport slave (
    input  pll_lock,
    input  btn_rst,
    input  init_done,
    input  loader_txd,
    input  soc_txd,
    output soc_rst_n,
    output o_tx,
    output tx_sel,
    output boot_state,
    output rst_count
  );
endinterface

// File: rtl/boot_reset_seq.sv
// Board reset and boot sequencer: qualifies PLL lock, holds the SoC in reset
// for a fixed window, debounces the user reset button and hands the single
// UART TX pin from the loader to the SoC only during an idle gap on the line.
module boot_reset_seq #(
  parameter int POR_CYCLES      = 21,
  parameter int DEBOUNCE_CYCLES = 270000,
  parameter int IDLE_CYCLES     = 2344,
  parameter int LOCK_CYCLES     = 64
) (
  input  logic            clk,
  input  logic            rst,
  boot_reset_seq_if.slave bus
);

  localparam int LOCK_W = $clog2(LOCK_CYCLES + 1);
  localparam int HOLD_W = $clog2(POR_CYCLES + 1);
  localparam int IDLE_W = $clog2(IDLE_CYCLES + 1);
  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);

  typedef enum logic [2:0] {
    WAIT_LOCK = 3'd0,
    POR_HOLD  = 3'd1,
    LOADER    = 3'd2,
    SWITCH    = 3'd3,
    RUN       = 3'd4
  } state_t;

  // synchronizers
  logic lock_meta_q, lock_meta_d;
  logic lock_sync_q, lock_sync_d;
  logic btn_meta_q,  btn_meta_d;
  logic btn_sync_q,  btn_sync_d;

  // debounce
  logic            db_level_q, db_level_d;
  logic            db_prev_q,  db_prev_d;
  logic [DB_W-1:0] db_cnt_q,   db_cnt_d;
  logic            btn_press;

  // sequencer
  state_t            state_q,    state_d;
  logic [LOCK_W-1:0] lock_cnt_q, lock_cnt_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;
  logic [7:0]        rst_count_q, rst_count_d;

  // registered outputs
  logic soc_rst_n_q, soc_rst_n_d;
  logic tx_sel_q,    tx_sel_d;
  logic o_tx_q,      o_tx_d;

  logic lines_idle;
  logic lock_lost;

  // Two-flop synchronizers for the asynchronous lock and button inputs.
  always_comb begin
    lock_meta_d = bus.pll_lock;
    lock_sync_d = lock_meta_q;
    btn_meta_d  = bus.btn_rst;
    btn_sync_d  = btn_meta_q;
  end

  // Debounce: the accepted level flips only after the synced button has
  // disagreed with it for a full run of consecutive cycles; any agreement
  // in between restarts the run.
  always_comb begin
    db_level_d = db_level_q;
    db_prev_d  = db_level_q;
    db_cnt_d   = '0;
    if (btn_sync_q != db_level_q) begin
      if (db_cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
        db_level_d = btn_sync_q;
        db_cnt_d   = '0;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end
  end

  assign btn_press  = db_level_q & ~db_prev_q;
  assign lines_idle = bus.loader_txd & bus.soc_txd;
  assign lock_lost  = ~lock_sync_q && (state_q != WAIT_LOCK);

  // Press counter saturates so a stuck or abused button never wraps to zero.
  always_comb begin
    rst_count_d = rst_count_q;
    if (btn_press && (rst_count_q != 8'hFF)) begin
      rst_count_d = rst_count_q + 8'd1;
    end
  end

  // Boot sequence next state, with lock loss overriding a button press and
  // the press overriding anything the current state would do.
  always_comb begin
    state_d    = state_q;
    lock_cnt_d = lock_cnt_q;
    hold_cnt_d = hold_cnt_q;
    idle_cnt_d = idle_cnt_q;

    unique case (state_q)
      WAIT_LOCK: begin
        hold_cnt_d = '0;
        idle_cnt_d = '0;
        if (!lock_sync_q) begin
          lock_cnt_d = '0;
        end else if (lock_cnt_q == LOCK_W'(LOCK_CYCLES)) begin
          state_d    = POR_HOLD;
          lock_cnt_d = '0;
        end else begin
          lock_cnt_d = lock_cnt_q + 1'b1;
        end
      end
      POR_HOLD: begin
        if (hold_cnt_q == HOLD_W'(POR_CYCLES - 1)) begin
          state_d    = LOADER;
          hold_cnt_d = '0;
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      LOADER: begin
        if (bus.init_done) begin
          state_d    = SWITCH;
          idle_cnt_d = '0;
        end
      end
      SWITCH: begin
        if (!lines_idle) begin
          idle_cnt_d = '0;
        end else if (idle_cnt_q == IDLE_W'(IDLE_CYCLES - 1)) begin
          state_d    = RUN;
          idle_cnt_d = '0;
        end else begin
          idle_cnt_d = idle_cnt_q + 1'b1;
        end
      end
      RUN: begin
        state_d = RUN;
      end
      default: begin
        state_d    = WAIT_LOCK;
        lock_cnt_d = '0;
        hold_cnt_d = '0;
        idle_cnt_d = '0;
      end
    endcase

    // A press while still waiting for lock does not skip lock qualification;
    // it is only counted.
    if (lock_lost) begin
      state_d    = WAIT_LOCK;
      lock_cnt_d = '0;
      hold_cnt_d = '0;
      idle_cnt_d = '0;
    end else if (btn_press && (state_q != WAIT_LOCK)) begin
      state_d    = POR_HOLD;
      hold_cnt_d = '0;
      idle_cnt_d = '0;
    end
  end

  // Outputs are decoded from the next state so they register together with it;
  // the TX mux uses the registered select so the pin changes source one edge
  // after the select does.
  always_comb begin
    soc_rst_n_d = (state_d != WAIT_LOCK) && (state_d != POR_HOLD);
    tx_sel_d    = (state_d == RUN);
    o_tx_d      = tx_sel_q ? bus.soc_txd : bus.loader_txd;
  end

  // All state registers, with a synchronous restart to a quiet line and held reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      lock_meta_q <= 1'b0;
      lock_sync_q <= 1'b0;
      btn_meta_q  <= 1'b0;
      btn_sync_q  <= 1'b0;
      db_level_q  <= 1'b0;
      db_prev_q   <= 1'b0;
      db_cnt_q    <= '0;
      state_q     <= WAIT_LOCK;
      lock_cnt_q  <= '0;
      hold_cnt_q  <= '0;
      idle_cnt_q  <= '0;
      rst_count_q <= '0;
      soc_rst_n_q <= 1'b0;
      tx_sel_q    <= 1'b0;
      o_tx_q      <= 1'b1;
    end else begin
      lock_meta_q <= lock_meta_d;
      lock_sync_q <= lock_sync_d;
      btn_meta_q  <= btn_meta_d;
      btn_sync_q  <= btn_sync_d;
      db_level_q  <= db_level_d;
      db_prev_q   <= db_prev_d;
      db_cnt_q    <= db_cnt_d;
      state_q     <= state_d;
      lock_cnt_q  <= lock_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
      idle_cnt_q  <= idle_cnt_d;
      rst_count_q <= rst_count_d;
      soc_rst_n_q <= soc_rst_n_d;
      tx_sel_q    <= tx_sel_d;
      o_tx_q      <= o_tx_d;
    end
  end

  assign bus.soc_rst_n  = soc_rst_n_q;
  assign bus.tx_sel     = tx_sel_q;
  assign bus.o_tx       = o_tx_q;
  assign bus.boot_state = state_q;
  assign bus.rst_count  = rst_count_q;

endmodule
